// File: rtl/vend_ctrl.sv
// Drink vending sequencer: coin credit, selection check against price/stock,
// dispense handshake, then coin-by-coin change payout. i_reset is active-low.
module vend_ctrl #(
   parameter int CW           = 8,
   parameter int PRICE_TEA    = 10,
   parameter int PRICE_COKE   = 15,
   parameter int PRICE_COFFEE = 20,
   parameter int PRICE_MILK   = 25,
   parameter int STOCK_INIT   = 3
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_coin_valid,
   input  logic [CW-1:0] i_coin_value,
   input  logic          i_sel_valid,
   input  logic [2:0]    i_drink_sel,
   input  logic          i_cancel,
   output logic          o_disp_req,
   output logic [2:0]    o_disp_drink,
   input  logic          i_disp_ack,
   output logic          o_pay_req,
   output logic [CW-1:0] o_pay_coin,
   input  logic          i_pay_ack,
   output logic [CW-1:0] o_credit,
   output logic          o_busy,
   output logic          o_coin_rej,
   output logic          o_err_stock,
   output logic          o_err_funds
);

   typedef enum logic [1:0] {IDLE, CHECK, DISPENSE, PAYOUT} state_t;

   state_t               r_state, w_stateNext;
   logic [CW-1:0]        r_credit, w_creditNext;
   logic [3:0][3:0]      r_stock, w_stockNext;
   logic [2:0]           r_drink, w_drinkNext;
   logic                 r_dispReq, w_dispReqNext;
   logic [2:0]           r_dispDrink, w_dispDrinkNext;
   logic                 r_payReq, w_payReqNext;
   logic [CW-1:0]        r_payCoin, w_payCoinNext;
   logic                 r_busy;
   logic                 r_coinRej, w_coinRejNext;
   logic                 r_errStock, w_errStockNext;
   logic                 r_errFunds, w_errFundsNext;

   logic [CW:0]          w_sum;
   logic                 w_coinOk;
   logic                 w_selOk;
   logic [1:0]           w_idx;
   logic [CW-1:0]        w_price;
   logic [CW-1:0]        w_payLeft;

   function automatic logic [CW-1:0] priceOf(input logic [2:0] drink);
      case (drink)
         3'd1:    priceOf = CW'(PRICE_TEA);
         3'd2:    priceOf = CW'(PRICE_COKE);
         3'd3:    priceOf = CW'(PRICE_COFFEE);
         3'd4:    priceOf = CW'(PRICE_MILK);
         default: priceOf = '0;
      endcase
   endfunction

   // Largest change coin not exceeding the remaining credit (credit is never 0 here).
   function automatic logic [CW-1:0] denomOf(input logic [CW-1:0] amount);
      if (amount >= CW'(10))
         denomOf = CW'(10);
      else if (amount >= CW'(5))
         denomOf = CW'(5);
      else
         denomOf = CW'(1);
   endfunction

   assign w_sum     = {1'b0, r_credit} + {1'b0, i_coin_value};
   assign w_coinOk  = (i_coin_value == CW'(1))  || (i_coin_value == CW'(5)) ||
                      (i_coin_value == CW'(10)) || (i_coin_value == CW'(50));
   assign w_selOk   = (i_drink_sel >= 3'd1) && (i_drink_sel <= 3'd4);
   assign w_idx     = r_drink[1:0] - 2'd1;
   assign w_price   = priceOf(r_drink);
   assign w_payLeft = r_credit - r_payCoin;

   always_comb begin
      w_stateNext     = r_state;
      w_creditNext    = r_credit;
      w_stockNext     = r_stock;
      w_drinkNext     = r_drink;
      w_dispReqNext   = r_dispReq;
      w_dispDrinkNext = r_dispDrink;
      w_payReqNext    = r_payReq;
      w_payCoinNext   = r_payCoin;
      w_coinRejNext   = i_coin_valid && (r_state != IDLE);
      w_errStockNext  = 1'b0;
      w_errFundsNext  = 1'b0;
      case (r_state)
         IDLE: begin
            // A coin arriving alongside an acted-on cancel/selection is refused.
            if (i_cancel && (r_credit != '0)) begin
               w_stateNext   = PAYOUT;
               w_payReqNext  = 1'b1;
               w_payCoinNext = denomOf(r_credit);
               w_coinRejNext = i_coin_valid;
            end else if (i_sel_valid && w_selOk) begin
               w_stateNext   = CHECK;
               w_drinkNext   = i_drink_sel;
               w_coinRejNext = i_coin_valid;
            end else if (i_coin_valid) begin
               if (w_coinOk && !w_sum[CW])
                  w_creditNext = w_sum[CW-1:0];
               else
                  w_coinRejNext = 1'b1;
            end
         end
         CHECK: begin
            if (r_stock[w_idx] == 4'd0) begin
               w_errStockNext = 1'b1;
               w_stateNext    = IDLE;
            end else if (r_credit < w_price) begin
               w_errFundsNext = 1'b1;
               w_stateNext    = IDLE;
            end else begin
               w_creditNext         = r_credit - w_price;
               w_stockNext[w_idx]   = r_stock[w_idx] - 4'd1;
               w_stateNext          = DISPENSE;
               w_dispReqNext        = 1'b1;
               w_dispDrinkNext      = r_drink;
            end
         end
         DISPENSE: begin
            if (i_disp_ack) begin
               w_dispReqNext   = 1'b0;
               w_dispDrinkNext = 3'd0;
               if (r_credit != '0) begin
                  w_stateNext   = PAYOUT;
                  w_payReqNext  = 1'b1;
                  w_payCoinNext = denomOf(r_credit);
               end else begin
                  w_stateNext = IDLE;
               end
            end
         end
         PAYOUT: begin
            if (i_pay_ack) begin
               w_creditNext = w_payLeft;
               if (w_payLeft == '0) begin
                  w_payReqNext  = 1'b0;
                  w_payCoinNext = '0;
                  w_stateNext   = IDLE;
               end else begin
                  w_payCoinNext = denomOf(w_payLeft);
               end
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= IDLE;
         r_credit    <= '0;
         r_stock     <= {4{4'(STOCK_INIT)}};
         r_drink     <= 3'd0;
         r_dispReq   <= 1'b0;
         r_dispDrink <= 3'd0;
         r_payReq    <= 1'b0;
         r_payCoin   <= '0;
         r_busy      <= 1'b0;
         r_coinRej   <= 1'b0;
         r_errStock  <= 1'b0;
         r_errFunds  <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_credit    <= w_creditNext;
         r_stock     <= w_stockNext;
         r_drink     <= w_drinkNext;
         r_dispReq   <= w_dispReqNext;
         r_dispDrink <= w_dispDrinkNext;
         r_payReq    <= w_payReqNext;
         r_payCoin   <= w_payCoinNext;
         r_busy      <= (w_stateNext != IDLE);
         r_coinRej   <= w_coinRejNext;
         r_errStock  <= w_errStockNext;
         r_errFunds  <= w_errFundsNext;
      end
   end

   assign o_disp_req   = r_dispReq;
   assign o_disp_drink = r_dispDrink;
   assign o_pay_req    = r_payReq;
   assign o_pay_coin   = r_payCoin;
   assign o_credit     = r_credit;
   assign o_busy       = r_busy;
   assign o_coin_rej   = r_coinRej;
   assign o_err_stock  = r_errStock;
   assign o_err_funds  = r_errFunds;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: purchases, cancel payout, errors, overflow,
// same-cycle input priority and asynchronous reset mid-handshake.
module tb_vend_ctrl;

   logic       clk;
   logic       rst_n;
   logic       coin_valid;
   logic [7:0] coin_value;
   logic       sel_valid;
   logic [2:0] drink_sel;
   logic       cancel;
   logic       disp_req;
   logic [2:0] disp_drink;
   logic       disp_ack;
   logic       pay_req;
   logic [7:0] pay_coin;
   logic       pay_ack;
   logic [7:0] credit;
   logic       busy;
   logic       coin_rej;
   logic       err_stock;
   logic       err_funds;

   int compareCount = 0;
   int failCount    = 0;

   vend_ctrl dut (
      .i_clk        (clk),
      .i_reset      (rst_n),
      .i_coin_valid (coin_valid),
      .i_coin_value (coin_value),
      .i_sel_valid  (sel_valid),
      .i_drink_sel  (drink_sel),
      .i_cancel     (cancel),
      .o_disp_req   (disp_req),
      .o_disp_drink (disp_drink),
      .i_disp_ack   (disp_ack),
      .o_pay_req    (pay_req),
      .o_pay_coin   (pay_coin),
      .i_pay_ack    (pay_ack),
      .o_credit     (credit),
      .o_busy       (busy),
      .o_coin_rej   (coin_rej),
      .o_err_stock  (err_stock),
      .o_err_funds  (err_funds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compareCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic cv, input logic [7:0] val, input logic sv,
                                input logic [2:0] ds, input logic cn);
      coin_valid = cv;
      coin_value = val;
      sel_valid  = sv;
      drink_sel  = ds;
      cancel     = cn;
      tick();
      coin_valid = 1'b0;
      coin_value = 8'd0;
      sel_valid  = 1'b0;
      drink_sel  = 3'd0;
      cancel     = 1'b0;
   endtask

   task automatic insertCoin(input logic [7:0] val);
      applyStimulus(1'b1, val, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic selectDrink(input logic [2:0] ds);
      applyStimulus(1'b0, 8'd0, 1'b1, ds, 1'b0);
   endtask

   task automatic ackDisp;
      disp_ack = 1'b1;
      tick();
      disp_ack = 1'b0;
   endtask

   task automatic ackPay;
      pay_ack = 1'b1;
      tick();
      pay_ack = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      coin_valid = 1'b0;
      coin_value = 8'd0;
      sel_valid  = 1'b0;
      drink_sel  = 3'd0;
      cancel     = 1'b0;
      disp_ack   = 1'b0;
      pay_ack    = 1'b0;

      // Reset values while reset is held.
      #12;
      checkOutput("rst_credit", credit, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_disp_req", disp_req, 0);
      checkOutput("rst_pay_req", pay_req, 0);
      checkOutput("rst_pay_coin", pay_coin, 0);
      checkOutput("rst_disp_drink", disp_drink, 0);
      checkOutput("rst_coin_rej", coin_rej, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Coins 10+10, buy coke (15), 5 change.
      insertCoin(8'd10);
      checkOutput("t1_credit10", credit, 10);
      insertCoin(8'd10);
      checkOutput("t1_credit20", credit, 20);
      selectDrink(3'd2);
      checkOutput("t1_check_busy", busy, 1);
      checkOutput("t1_check_noreq", disp_req, 0);
      tick();
      checkOutput("t1_disp_req", disp_req, 1);
      checkOutput("t1_disp_drink", disp_drink, 2);
      checkOutput("t1_credit_after_price", credit, 5);
      insertCoin(8'd10);
      checkOutput("t1_coin_rej_busy", coin_rej, 1);
      checkOutput("t1_credit_hold", credit, 5);
      checkOutput("t1_disp_req_hold", disp_req, 1);
      ackDisp();
      checkOutput("t1_disp_req_drop", disp_req, 0);
      checkOutput("t1_pay_req", pay_req, 1);
      checkOutput("t1_pay_coin", pay_coin, 5);
      ackPay();
      checkOutput("t1_credit_end", credit, 0);
      checkOutput("t1_pay_req_end", pay_req, 0);
      checkOutput("t1_idle", busy, 0);

      // Coins 10,5,1,1 then cancel: payout 10,5,1,1.
      insertCoin(8'd10);
      insertCoin(8'd5);
      insertCoin(8'd1);
      insertCoin(8'd1);
      checkOutput("t2_credit17", credit, 17);
      applyStimulus(1'b0, 8'd0, 1'b0, 3'd0, 1'b1);
      checkOutput("t2_pay_req", pay_req, 1);
      checkOutput("t2_coin10", pay_coin, 10);
      tick();
      checkOutput("t2_coin10_held", pay_coin, 10);
      checkOutput("t2_credit_held", credit, 17);
      ackPay();
      checkOutput("t2_coin5", pay_coin, 5);
      checkOutput("t2_credit7", credit, 7);
      ackPay();
      checkOutput("t2_coin1a", pay_coin, 1);
      checkOutput("t2_credit2", credit, 2);
      ackPay();
      checkOutput("t2_coin1b", pay_coin, 1);
      checkOutput("t2_pay_req_still", pay_req, 1);
      ackPay();
      checkOutput("t2_credit0", credit, 0);
      checkOutput("t2_pay_req_end", pay_req, 0);
      checkOutput("t2_no_disp", disp_req, 0);
      checkOutput("t2_idle", busy, 0);

      // Credit 15, milk costs 25: funds error; bad coin 7 refused.
      insertCoin(8'd10);
      insertCoin(8'd5);
      selectDrink(3'd4);
      tick();
      checkOutput("t3_err_funds", err_funds, 1);
      checkOutput("t3_err_stock", err_stock, 0);
      checkOutput("t3_credit15", credit, 15);
      checkOutput("t3_idle", busy, 0);
      insertCoin(8'd7);
      checkOutput("t3_err_funds_pulse", err_funds, 0);
      checkOutput("t3_coin_rej7", coin_rej, 1);
      checkOutput("t3_credit_kept", credit, 15);
      tick();
      checkOutput("t3_coin_rej_pulse", coin_rej, 0);
      applyStimulus(1'b0, 8'd0, 1'b0, 3'd0, 1'b1);
      checkOutput("t3_cancel_coin10", pay_coin, 10);
      ackPay();
      checkOutput("t3_cancel_coin5", pay_coin, 5);
      ackPay();
      checkOutput("t3_cancel_done", credit, 0);

      // Exhaust tea stock (3), then sold-out error; overflow boundary.
      for (int i = 0; i < 3; i++) begin
         insertCoin(8'd10);
         selectDrink(3'd1);
         tick();
         checkOutput("t4_tea_disp_req", disp_req, 1);
         checkOutput("t4_tea_drink", disp_drink, 1);
         ackDisp();
         checkOutput("t4_tea_no_payout", pay_req, 0);
         checkOutput("t4_tea_idle", busy, 0);
      end
      insertCoin(8'd10);
      insertCoin(8'd10);
      selectDrink(3'd1);
      tick();
      checkOutput("t4_err_stock", err_stock, 1);
      checkOutput("t4_err_funds_none", err_funds, 0);
      checkOutput("t4_credit20", credit, 20);
      checkOutput("t4_no_disp", disp_req, 0);
      for (int i = 0; i < 4; i++) insertCoin(8'd50);
      for (int i = 0; i < 3; i++) insertCoin(8'd10);
      checkOutput("t4_credit250", credit, 250);
      insertCoin(8'd50);
      checkOutput("t4_ovf_rej", coin_rej, 1);
      checkOutput("t4_ovf_credit", credit, 250);
      insertCoin(8'd5);
      checkOutput("t4_max_accept", coin_rej, 0);
      checkOutput("t4_credit255", credit, 255);
      insertCoin(8'd1);
      checkOutput("t4_ovf1_rej", coin_rej, 1);
      checkOutput("t4_ovf1_credit", credit, 255);

      // Reset asserted mid-dispense drops outputs without a clock edge.
      selectDrink(3'd2);
      tick();
      checkOutput("t6_disp_req_before", disp_req, 1);
      checkOutput("t6_credit240", credit, 240);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_async_disp_req", disp_req, 0);
      checkOutput("t6_async_credit", credit, 0);
      checkOutput("t6_async_busy", busy, 0);
      checkOutput("t6_async_disp_drink", disp_drink, 0);
      #1;
      rst_n = 1'b1;
      tick();
      checkOutput("t6_after_credit", credit, 0);
      checkOutput("t6_after_busy", busy, 0);
      checkOutput("t6_after_disp_req", disp_req, 0);
      insertCoin(8'd10);
      selectDrink(3'd1);
      tick();
      checkOutput("t6_stock_restored", disp_req, 1);
      checkOutput("t6_stock_err_none", err_stock, 0);
      ackDisp();
      checkOutput("t6_idle", busy, 0);

      // Cancel + select + coin in one cycle with credit 10.
      insertCoin(8'd10);
      applyStimulus(1'b1, 8'd5, 1'b1, 3'd2, 1'b1);
      checkOutput("t5_pay_req", pay_req, 1);
      checkOutput("t5_pay_coin", pay_coin, 10);
      checkOutput("t5_coin_rej", coin_rej, 1);
      checkOutput("t5_credit10", credit, 10);
      tick();
      checkOutput("t5_no_check", disp_req, 0);
      checkOutput("t5_still_payout", pay_req, 1);
      checkOutput("t5_rej_pulse", coin_rej, 0);
      ackPay();
      checkOutput("t5_credit0", credit, 0);
      checkOutput("t5_idle", busy, 0);

      // Cancel at zero credit is ignored; coin still taken. Invalid code too.
      applyStimulus(1'b1, 8'd5, 1'b0, 3'd0, 1'b1);
      checkOutput("t7_cancel0_coin", credit, 5);
      checkOutput("t7_cancel0_idle", busy, 0);
      checkOutput("t7_cancel0_rej", coin_rej, 0);
      applyStimulus(1'b1, 8'd1, 1'b1, 3'd6, 1'b0);
      checkOutput("t7_badsel_coin", credit, 6);
      checkOutput("t7_badsel_idle", busy, 0);
      selectDrink(3'd1);
      tick();
      checkOutput("t7_err_funds", err_funds, 1);
      checkOutput("t7_credit6", credit, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
